// File: rtl/enemy_group.sv
// rtl/enemy_group.sv - grid enemy controller: turn-based stepping, kill strobe, cell renderer
module enemy_group #(
    parameter int         N_ENEMIES   = 4,
    parameter int         CELL_LOG2   = 6,
    parameter int         GRID_W      = 16,
    parameter int         GRID_H      = 12,
    parameter logic [3:0] PLAY_STATE  = 4'd2,
    parameter logic [3:0] ENEMY_TURN  = 4'd1,
    parameter logic [11:0] ENEMY_COLOR = 12'hF00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [10:0]          hcount_in,
    input  logic [9:0]           vcount_in,
    input  logic [3:0]           state_in,
    input  logic [3:0]           turn_in,
    input  logic [1:0]           rotate_in,
    input  logic                 kill_valid_in,
    input  logic [3:0]           kill_idx_in,
    output logic [N_ENEMIES-1:0] alive_out,
    output logic                 busy_out,
    output logic                 finished_out,
    output logic [11:0]          pixel_out
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam int IW = (N_ENEMIES > 1) ? $clog2(N_ENEMIES) : 1;

    localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_ENEMIES - 1);
    localparam logic [11:0]   H_LIM    = 12'(GRID_W << CELL_LOG2);
    localparam logic [10:0]   V_LIM    = 11'(GRID_H << CELL_LOG2);

    typedef enum logic [1:0] {IDLE, MOVE, DONE} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic              go, go_q, trig;

    logic [XW-1:0]     xs [N_ENEMIES];
    logic [YW-1:0]     ys [N_ENEMIES];
    logic [N_ENEMIES-1:0] alive;

    logic [XW-1:0]     cur_x, tx;
    logic [YW-1:0]     cur_y, ty;
    logic              in_range, blocked, kill_ok, kill_here, move_en;

    logic [10:0]       cx;
    logic [9:0]        cy;
    logic              visible, hit;

    assign go   = (state_in == PLAY_STATE) && (turn_in == ENEMY_TURN);
    assign trig = go && !go_q;

    assign kill_ok   = kill_valid_in && ({1'b0, kill_idx_in} < 5'(N_ENEMIES));
    assign kill_here = kill_ok && (kill_idx_in == 4'(idx));

    assign alive_out    = alive;
    assign busy_out     = (state == MOVE);
    assign finished_out = (state == DONE);

    // go history for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) go_q <= 1'b0;
        else     go_q <= go;
    end

    // FSM state and slot index register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // FSM next state: abort on go loss, DONE lasts one cycle
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            IDLE: begin
                if (trig) begin
                    state_nx = MOVE;
                    idx_nx   = '0;
                end
            end
            MOVE: begin
                if (!go)                   state_nx = IDLE;
                else if (idx == IDX_LAST)  state_nx = DONE;
                else                       idx_nx   = idx + IW'(1);
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // target cell of the indexed slot, clamped to the grid and blocked by other live slots
    always_comb begin
        cur_x    = xs[idx];
        cur_y    = ys[idx];
        tx       = cur_x;
        ty       = cur_y;
        in_range = 1'b0;
        blocked  = 1'b0;
        case (rotate_in)
            2'd0: begin in_range = (cur_x != X_MAX); tx = cur_x + XW'(1); end
            2'd1: begin in_range = (cur_y != Y_MAX); ty = cur_y + YW'(1); end
            2'd2: begin in_range = (cur_x != '0);    tx = cur_x - XW'(1); end
            default: begin in_range = (cur_y != '0); ty = cur_y - YW'(1); end
        endcase
        for (int j = 0; j < N_ENEMIES; j++) begin
            if ((IW'(j) != idx) && alive[j] && (xs[j] == tx) && (ys[j] == ty))
                blocked = 1'b1;
        end
        move_en = (state == MOVE) && go && alive[idx] && !kill_here && in_range && !blocked;
    end

    // slot positions and alive bits; a same-cycle kill suppresses the move via move_en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_ENEMIES; i++) begin
                xs[i] <= XW'(2 * i);
                ys[i] <= '0;
            end
            alive <= '1;
        end else begin
            if (move_en) begin
                xs[idx] <= tx;
                ys[idx] <= ty;
            end
            for (int i = 0; i < N_ENEMIES; i++) begin
                if (kill_ok && (kill_idx_in == 4'(i)))
                    alive[i] <= 1'b0;
            end
        end
    end

    // cell lookup for the current raster position
    always_comb begin
        cx      = hcount_in >> CELL_LOG2;
        cy      = vcount_in >> CELL_LOG2;
        visible = ({1'b0, hcount_in} < H_LIM) && ({1'b0, vcount_in} < V_LIM);
        hit     = 1'b0;
        for (int i = 0; i < N_ENEMIES; i++) begin
            if (alive[i] && (cx == 11'(xs[i])) && (cy == 10'(ys[i])))
                hit = 1'b1;
        end
    end

    // registered pixel, one cycle behind the raster counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 pixel_out <= 12'h000;
        else if (visible && hit) pixel_out <= ENEMY_COLOR;
        else                     pixel_out <= 12'h000;
    end

endmodule

// File: tb/tb_enemy_group.sv
// tb/tb_enemy_group.sv - directed self-checking bench for enemy_group
module tb_enemy_group;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [3:0]  state_in;
    logic [3:0]  turn_in;
    logic [1:0]  rotate_in;
    logic        kill_valid_in;
    logic [3:0]  kill_idx_in;
    logic [3:0]  alive_out;
    logic        busy_out;
    logic        finished_out;
    logic [11:0] pixel_out;

    int n_checks = 0;
    int n_fail   = 0;

    int       ex [4];
    int       ey [4];
    logic [3:0] ealive;

    enemy_group dut (
        .clk          (clk),
        .rst          (rst),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .state_in     (state_in),
        .turn_in      (turn_in),
        .rotate_in    (rotate_in),
        .kill_valid_in(kill_valid_in),
        .kill_idx_in  (kill_idx_in),
        .alive_out    (alive_out),
        .busy_out     (busy_out),
        .finished_out (finished_out),
        .pixel_out    (pixel_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int k, input int x, input int y);
        ex[k] = x;
        ey[k] = y;
    endtask

    function automatic logic [11:0] exp_pix(input int cx, input int cy);
        exp_pix = 12'h000;
        for (int k = 0; k < 4; k++)
            if (ealive[k] && ex[k] == cx && ey[k] == cy) exp_pix = 12'hF00;
    endfunction

    task automatic probe(input string tag, input int h, input int v, input logic [11:0] exp);
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        tick();
        check_val(tag, pixel_out, exp);
    endtask

    task automatic check_grid(input string tag);
        for (int cy = 0; cy < 12; cy++)
            for (int cx = 0; cx < 16; cx++)
                probe(tag, cx * 64 + 32, cy * 64 + 32, exp_pix(cx, cy));
        check_val({tag, "_alive"}, alive_out, ealive);
    endtask

    task automatic run_phase(input logic [1:0] rot, input int hold);
        rotate_in = rot;
        state_in  = 4'd2;
        turn_in   = 4'd1;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_val("phase_busy", busy_out, 1);
            check_val("phase_fin_low", finished_out, 0);
            tick();
        end
        check_val("done_busy_low", busy_out, 0);
        check_val("done_fin", finished_out, 1);
        tick();
        check_val("fin_one_cycle", finished_out, 0);
        for (int k = 0; k < hold; k++) begin
            tick();
            check_val("hold_no_retrigger", {busy_out, finished_out}, 0);
        end
        state_in = 4'd0;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        hcount_in = '0; vcount_in = '0;
        state_in = '0; turn_in = '0; rotate_in = '0;
        kill_valid_in = 1'b0; kill_idx_in = '0;
        for (int k = 0; k < 4; k++) set_pos(k, 2 * k, 0);
        ealive = 4'hF;

        tick(); tick();
        check_val("rst_busy", busy_out, 0);
        check_val("rst_fin", finished_out, 0);
        check_val("rst_pix", pixel_out, 0);
        check_val("rst_alive", alive_out, 4'hF);
        rst = 1'b0;
        tick();

        // reset placement, cell edges, out-of-field and latency
        check_grid("grid_reset");
        probe("edge_63", 63, 0, 12'hF00);
        probe("edge_64", 64, 0, 12'h000);
        probe("edge_c2_y63", 128, 63, 12'hF00);
        probe("edge_c2_y64", 128, 64, 12'h000);
        probe("cell6", 384, 10, 12'hF00);
        probe("cell7", 448, 10, 12'h000);
        probe("h_1024", 1024, 0, 12'h000);
        probe("corner", 1023, 767, 12'h000);
        probe("lat_a", 0, 0, 12'hF00);
        hcount_in = 11'd100;
        #1;
        check_val("lat_hold", pixel_out, 12'hF00);
        tick();
        check_val("lat_b", pixel_out, 12'h000);

        // step +x, then hold go for 20 cycles
        run_phase(2'd0, 20);
        for (int k = 0; k < 4; k++) set_pos(k, 2 * k + 1, 0);
        check_grid("grid_px");

        // -y at top row clamps
        run_phase(2'd3, 0);
        check_grid("grid_clamp");

        // walk down to row 5, then left into the wall and each other
        for (int n = 0; n < 5; n++) run_phase(2'd1, 0);
        for (int k = 0; k < 4; k++) set_pos(k, 2 * k + 1, 5);
        check_grid("grid_down5");
        for (int n = 0; n < 3; n++) run_phase(2'd2, 0);
        set_pos(0, 0, 5); set_pos(1, 1, 5); set_pos(2, 2, 5); set_pos(3, 4, 5);
        check_grid("grid_block_left");
        run_phase(2'd0, 0);
        set_pos(2, 3, 5); set_pos(3, 5, 5);
        check_grid("grid_block_right");

        // kill slot 2 in the cycle it is indexed
        rotate_in = 2'd1;
        state_in  = 4'd2;
        turn_in   = 4'd1;
        tick(); tick(); tick();
        kill_valid_in = 1'b1;
        kill_idx_in   = 4'd2;
        tick();
        kill_valid_in = 1'b0;
        check_val("kill_alive", alive_out, 4'b1011);
        check_val("kill_busy", busy_out, 1);
        tick();
        check_val("kill_fin", finished_out, 1);
        tick();
        state_in = 4'd0;
        tick();
        set_pos(0, 0, 6); set_pos(1, 1, 6); set_pos(3, 5, 6);
        ealive = 4'b1011;
        check_grid("grid_kill");
        probe("dead_cell", 3 * 64 + 5, 5 * 64 + 5, 12'h000);

        kill_valid_in = 1'b1;
        kill_idx_in   = 4'd9;
        tick();
        kill_valid_in = 1'b0;
        tick();
        check_val("kill_oob", alive_out, 4'b1011);

        // abort after two move cycles
        rotate_in = 2'd3;
        state_in  = 4'd2;
        turn_in   = 4'd1;
        tick(); tick(); tick();
        state_in = 4'd0;
        tick();
        check_val("abort_busy", busy_out, 0);
        check_val("abort_fin", finished_out, 0);
        tick();
        check_val("abort_fin2", finished_out, 0);
        set_pos(0, 0, 5); set_pos(1, 1, 5);
        check_grid("grid_abort");

        // asynchronous reset mid-phase
        hcount_in = 11'(5 * 64 + 5);
        vcount_in = 10'(6 * 64 + 5);
        rotate_in = 2'd0;
        state_in  = 4'd2;
        turn_in   = 4'd1;
        tick(); tick(); tick();
        check_val("pre_rst_busy", busy_out, 1);
        check_val("pre_rst_pix", pixel_out, 12'hF00);
        rst = 1'b1;
        #1;
        check_val("arst_busy", busy_out, 0);
        check_val("arst_fin", finished_out, 0);
        check_val("arst_pix", pixel_out, 0);
        check_val("arst_alive", alive_out, 4'hF);
        state_in = 4'd0;
        rst = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) set_pos(k, 2 * k, 0);
        ealive = 4'hF;
        check_grid("grid_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
